// File: rtl/tpm_port_requester.sv
// tpm_port_requester
// Drives a single memory port on behalf of one client. Requests are registered
// onto the port one cycle after acceptance and held while the memory asserts
// mem_freeze_inputs. Read returns are buffered in a show-ahead response FIFO
// whose depth also bounds the number of reads that may be in flight, so a
// well-behaved memory can never overrun it. A drain handshake lets the
// surrounding logic quiesce the port before reconfiguration.

module tpm_port_requester #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int RSP_DEPTH = 4,
  localparam int CW       = $clog2(RSP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,

  // Client request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_wen,

  // Memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              mem_valid_in,
  input  logic              mem_freeze_inputs,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_valid_out,

  // Client response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,

  // Drain control and status
  input  logic              drain_req,
  output logic              drain_done,
  output logic [CW-1:0]     outstanding,
  output logic              err
);

  // Pointer width; RSP_DEPTH is a power of two so pointers wrap for free.
  localparam int PW = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAINING,
    ST_DRAINED
  } state_e;

  state_e state_q, state_d;

  // Registered memory-port drive
  logic              mem_valid_in_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_wen_q;

  // Response FIFO and credit bookkeeping
  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic              err_q, err_d;

  // Handshake qualifiers
  logic          credit_ok;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          accept_rd;
  logic          pop;
  logic          push;
  logic          drop;
  logic [CW-1:0] outstanding_w;

  // ---------------------------------------------------------------------------
  // Handshake and FIFO status decode
  // ---------------------------------------------------------------------------
  assign credit_ok     = credits_q < CW'(RSP_DEPTH);
  assign fifo_full     = count_q == CW'(RSP_DEPTH);
  assign fifo_empty    = count_q == '0;
  assign outstanding_w = credits_q - count_q;

  assign accept    = req_valid & req_ready;
  assign accept_rd = accept & ~req_wen;
  assign pop       = ~fifo_empty & rsp_ready;

  // A return is only legitimate if a read is actually in flight. A full FIFO
  // can still take it when the head is leaving in the same cycle.
  assign push = mem_valid_out & (outstanding_w != '0) & (~fifo_full | pop);
  assign drop = mem_valid_out & ~push;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Next-state: leave RUN on a drain request, finish draining once no read is
  // in flight and the port holds no request the memory has yet to capture.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAINING;
      end
      ST_DRAINING: begin
        if ((outstanding_w == '0) && (!mem_valid_in_q || !mem_freeze_inputs))
          state_d = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs decoded from state: only RUN accepts work, DRAINED reports done.
  always_comb begin
    req_ready  = 1'b0;
    drain_done = 1'b0;
    unique case (state_q)
      ST_RUN:      req_ready  = ~mem_freeze_inputs & credit_ok;
      ST_DRAINING: req_ready  = 1'b0;
      ST_DRAINED:  drain_done = 1'b1;
      default:     req_ready  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory port drive
  // ---------------------------------------------------------------------------

  // Register accepted requests onto the port; freeze holds everything as is.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_valid_in_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wen_q      <= 1'b0;
    end else if (!mem_freeze_inputs) begin
      mem_valid_in_q <= accept;
      if (accept) begin
        mem_addr_q  <= req_addr;
        mem_wdata_q <= req_wdata;
        mem_wen_q   <= req_wen;
      end
    end
  end

  assign mem_valid_in = mem_valid_in_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wen      = mem_wen_q;

  // ---------------------------------------------------------------------------
  // Response FIFO, credits and error
  // ---------------------------------------------------------------------------

  // Next values for pointers, occupancy, credits and the sticky error.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    credits_d = credits_q + CW'(accept_rd) - CW'(pop);
    err_d     = err_q | drop;
  end

  // Control registers of the FIFO; reset discards any reads still in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      credits_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  // Response storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy is tracked by count_q,
    // so stale entries are never visible and the array maps to plain RAM.
    if (push) fifo_mem[wr_ptr_q] <= mem_data_out;
  end

  assign rsp_valid   = ~fifo_empty;
  assign rsp_data    = fifo_mem[rd_ptr_q];
  assign outstanding = outstanding_w;
  assign err         = err_q;

endmodule

// File: tb/tb_tpm_port_requester.sv
// Self-checking bench for tpm_port_requester: a table of single-cycle vectors
// for the basic request/return behaviour, followed by hand-written sequences
// for freeze, credit back-pressure, streaming across pointer wrap, drain and
// reset during operation.

module tb_tpm_port_requester;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int RSP_DEPTH = 4;
  localparam int CW        = $clog2(RSP_DEPTH + 1);

  logic              clk;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic              mem_valid_in;
  logic              mem_freeze_inputs;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_valid_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              drain_req;
  logic              drain_done;
  logic [CW-1:0]     outstanding;
  logic              err;

  int n_vec = 0;
  int n_err = 0;

  tpm_port_requester #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_wen          (req_wen),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wen          (mem_wen),
    .mem_valid_in     (mem_valid_in),
    .mem_freeze_inputs(mem_freeze_inputs),
    .mem_data_out     (mem_data_out),
    .mem_valid_out    (mem_valid_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .drain_req        (drain_req),
    .drain_done       (drain_done),
    .outstanding      (outstanding),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: inputs held across one rising edge. e_rdy is the
  // combinational req_ready before the edge; the rest are sampled after it.
  typedef struct {
    logic              rv;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rwd;
    logic              rwen;
    logic              frz;
    logic              mvo;
    logic [DATA_W-1:0] mdo;
    logic              rrdy;
    logic              e_rdy;
    logic              e_mvi;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_wen;
    logic              e_rspv;
    logic [DATA_W-1:0] e_rspd;
    logic [CW-1:0]     e_out;
    logic              e_err;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mkv(
    input logic rv, input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] rwd,
    input logic rwen, input logic frz, input logic mvo, input logic [DATA_W-1:0] mdo,
    input logic rrdy, input logic e_rdy, input logic e_mvi,
    input logic [ADDR_W-1:0] e_addr, input logic [DATA_W-1:0] e_wdata, input logic e_wen,
    input logic e_rspv, input logic [DATA_W-1:0] e_rspd, input logic [CW-1:0] e_out,
    input logic e_err);
    vec_t v;
    v.rv = rv; v.ra = ra; v.rwd = rwd; v.rwen = rwen; v.frz = frz;
    v.mvo = mvo; v.mdo = mdo; v.rrdy = rrdy;
    v.e_rdy = e_rdy; v.e_mvi = e_mvi; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_wen = e_wen; v.e_rspv = e_rspv; v.e_rspd = e_rspd; v.e_out = e_out;
    v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    req_valid         = 1'b0;
    req_addr          = '0;
    req_wdata         = '0;
    req_wen           = 1'b0;
    mem_freeze_inputs = 1'b0;
    mem_valid_out     = 1'b0;
    mem_data_out      = '0;
    rsp_ready         = 1'b0;
    drain_req         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] a);
    set_idle();
    req_valid = 1'b1;
    req_addr  = a;
    #1 check("issue_ready", 32'(req_ready), 32'd1);
    tick();
    set_idle();
  endtask

  task automatic ret(input logic [DATA_W-1:0] d, input logic pop_too);
    set_idle();
    mem_valid_out = 1'b1;
    mem_data_out  = d;
    rsp_ready     = pop_too;
    tick();
    set_idle();
  endtask

  task automatic pop_expect(input string name, input logic [DATA_W-1:0] d);
    check({name, "_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_data"}, 32'(rsp_data), 32'(d));
    set_idle();
    rsp_ready = 1'b1;
    tick();
    set_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    reset_n = 1'b0;
    do_reset();

    // Reset state
    check("rst_mvi",   32'(mem_valid_in), 32'd0);
    check("rst_addr",  32'(mem_addr),     32'd0);
    check("rst_wdata", 32'(mem_wdata),    32'd0);
    check("rst_wen",   32'(mem_wen),      32'd0);
    check("rst_rspv",  32'(rsp_valid),    32'd0);
    check("rst_out",   32'(outstanding),  32'd0);
    check("rst_err",   32'(err),          32'd0);
    check("rst_done",  32'(drain_done),   32'd0);
    check("rst_ready", 32'(req_ready),    32'd1);

    // ---------------- Table-driven vectors ----------------
    //               rv  addr    wdata     wen frz mvo mdo       rrdy| rdy mvi addr    wdata     wen rspv rspd      out err
    vecs[0]  = mkv(0, 12'h000, 16'h0000, 0, 0, 0, 16'h0000, 0,   1, 0, 12'h000, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vecs[1]  = mkv(1, 12'h010, 16'hBEEF, 1, 0, 0, 16'h0000, 0,   1, 1, 12'h010, 16'hBEEF, 1, 0, 16'h0000, 0, 0);
    vecs[2]  = mkv(0, 12'h000, 16'h0000, 0, 0, 0, 16'h0000, 0,   1, 0, 12'h010, 16'hBEEF, 1, 0, 16'h0000, 0, 0);
    vecs[3]  = mkv(1, 12'h0AA, 16'h1234, 0, 0, 0, 16'h0000, 0,   1, 1, 12'h0AA, 16'h1234, 0, 0, 16'h0000, 1, 0);
    vecs[4]  = mkv(0, 12'h000, 16'h0000, 0, 0, 0, 16'h0000, 0,   1, 0, 12'h0AA, 16'h1234, 0, 0, 16'h0000, 1, 0);
    vecs[5]  = mkv(0, 12'h000, 16'h0000, 0, 0, 1, 16'h5A5A, 0,   1, 0, 12'h0AA, 16'h1234, 0, 1, 16'h5A5A, 0, 0);
    vecs[6]  = mkv(0, 12'h000, 16'h0000, 0, 0, 0, 16'h0000, 1,   1, 0, 12'h0AA, 16'h1234, 0, 0, 16'h0000, 0, 0);
    vecs[7]  = mkv(1, 12'h0FF, 16'h00FF, 1, 1, 0, 16'h0000, 0,   0, 0, 12'h0AA, 16'h1234, 0, 0, 16'h0000, 0, 0);
    vecs[8]  = mkv(1, 12'h0FF, 16'h00FF, 1, 0, 0, 16'h0000, 0,   1, 1, 12'h0FF, 16'h00FF, 1, 0, 16'h0000, 0, 0);
    vecs[9]  = mkv(0, 12'h000, 16'h0000, 0, 0, 1, 16'hDEAD, 0,   1, 0, 12'h0FF, 16'h00FF, 1, 0, 16'h0000, 0, 1);
    vecs[10] = mkv(0, 12'h000, 16'h0000, 0, 0, 0, 16'h0000, 0,   1, 0, 12'h0FF, 16'h00FF, 1, 0, 16'h0000, 0, 1);
    vecs[11] = mkv(1, 12'h0CC, 16'h0000, 0, 0, 0, 16'h0000, 0,   1, 1, 12'h0CC, 16'h0000, 0, 0, 16'h0000, 1, 1);
    vecs[12] = mkv(0, 12'h000, 16'h0000, 0, 0, 1, 16'h1111, 0,   1, 0, 12'h0CC, 16'h0000, 0, 1, 16'h1111, 0, 1);
    vecs[13] = mkv(0, 12'h000, 16'h0000, 0, 0, 0, 16'h0000, 1,   1, 0, 12'h0CC, 16'h0000, 0, 0, 16'h0000, 0, 1);

    for (int i = 0; i < 14; i++) begin
      req_valid         = vecs[i].rv;
      req_addr          = vecs[i].ra;
      req_wdata         = vecs[i].rwd;
      req_wen           = vecs[i].rwen;
      mem_freeze_inputs = vecs[i].frz;
      mem_valid_out     = vecs[i].mvo;
      mem_data_out      = vecs[i].mdo;
      rsp_ready         = vecs[i].rrdy;
      drain_req         = 1'b0;
      #1 check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      tick();
      check($sformatf("v%0d_mvi", i),   32'(mem_valid_in), 32'(vecs[i].e_mvi));
      check($sformatf("v%0d_addr", i),  32'(mem_addr),     32'(vecs[i].e_addr));
      check($sformatf("v%0d_wdata", i), 32'(mem_wdata),    32'(vecs[i].e_wdata));
      check($sformatf("v%0d_wen", i),   32'(mem_wen),      32'(vecs[i].e_wen));
      check($sformatf("v%0d_rspv", i),  32'(rsp_valid),    32'(vecs[i].e_rspv));
      if (vecs[i].e_rspv)
        check($sformatf("v%0d_rspd", i), 32'(rsp_data), 32'(vecs[i].e_rspd));
      check($sformatf("v%0d_out", i),   32'(outstanding),  32'(vecs[i].e_out));
      check($sformatf("v%0d_err", i),   32'(err),          32'(vecs[i].e_err));
    end

    // Sticky error clears only through reset
    set_idle();
    do_reset();
    check("err_cleared", 32'(err), 32'd0);

    // ---------------- Freeze holds the port ----------------
    issue_read(12'h123);
    req_valid         = 1'b1;
    req_addr          = 12'h456;
    req_wdata         = 16'hCAFE;
    req_wen           = 1'b1;
    mem_freeze_inputs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("frz%0d_ready", k), 32'(req_ready), 32'd0);
      tick();
      check($sformatf("frz%0d_mvi", k),   32'(mem_valid_in), 32'd1);
      check($sformatf("frz%0d_addr", k),  32'(mem_addr),     32'h123);
      check($sformatf("frz%0d_wen", k),   32'(mem_wen),      32'd0);
      check($sformatf("frz%0d_wdata", k), 32'(mem_wdata),    32'd0);
    end
    set_idle();
    tick();
    check("unfrz_mvi",  32'(mem_valid_in), 32'd0);
    check("unfrz_addr", 32'(mem_addr),     32'h123);
    check("unfrz_out",  32'(outstanding),  32'd1);
    ret(16'h7777, 1'b0);
    check("frz_ret_out", 32'(outstanding), 32'd0);
    pop_expect("frz_pop", 16'h7777);
    check("frz_empty", 32'(rsp_valid), 32'd0);

    // ---------------- Credit limit and FIFO full ----------------
    for (int i = 0; i < 4; i++) issue_read(ADDR_W'(12'h200 + i));
    #1 check("cred_ready", 32'(req_ready), 32'd0);
    check("cred_out4", 32'(outstanding), 32'd4);
    for (int i = 0; i < 4; i++) begin
      ret(DATA_W'(i + 1), 1'b0);
      check($sformatf("cred_out_%0d", i), 32'(outstanding), 32'(3 - i));
      check($sformatf("cred_head_%0d", i), 32'(rsp_data), 32'h0001);
    end
    check("full_err", 32'(err), 32'd0);
    #1 check("full_ready", 32'(req_ready), 32'd0);
    pop_expect("full_pop1", 16'h0001);
    #1 check("after_pop_ready", 32'(req_ready), 32'd1);
    for (int i = 2; i <= 4; i++) pop_expect($sformatf("full_pop%0d", i), DATA_W'(i));
    check("full_drained", 32'(rsp_valid), 32'd0);

    // ---------------- Streaming push/pop at the credit limit, across wrap ----
    for (int i = 0; i < 4; i++) issue_read(ADDR_W'(12'h300 + i));
    ret(16'hA000, 1'b0);
    ret(16'hA001, 1'b0);
    ret(16'hA002, 1'b0);
    check("strm_out1", 32'(outstanding), 32'd1);
    ret(16'hA003, 1'b1);
    check("strm_pp_out",  32'(outstanding), 32'd0);
    check("strm_pp_err",  32'(err),         32'd0);
    check("strm_pp_head", 32'(rsp_data),    32'hA001);
    req_valid = 1'b1;
    req_addr  = 12'h304;
    rsp_ready = 1'b1;
    #1 check("strm_acc_ready", 32'(req_ready), 32'd1);
    tick();
    set_idle();
    check("strm_acc_out",  32'(outstanding), 32'd1);
    check("strm_acc_head", 32'(rsp_data),    32'hA002);
    ret(16'hA004, 1'b1);
    check("strm_pp2_out",  32'(outstanding), 32'd0);
    check("strm_pp2_err",  32'(err),         32'd0);
    #1 check("strm_ready", 32'(req_ready), 32'd1);
    pop_expect("strm_pop3", 16'hA003);
    pop_expect("strm_pop4", 16'hA004);
    check("strm_empty", 32'(rsp_valid), 32'd0);

    // ---------------- Drain ----------------
    issue_read(12'h400);
    issue_read(12'h401);
    drain_req = 1'b1;
    #1 check("drn_run_ready", 32'(req_ready), 32'd1);
    tick();
    #1 check("drn_ready0", 32'(req_ready), 32'd0);
    check("drn_done0", 32'(drain_done), 32'd0);
    tick();
    check("drn_done1", 32'(drain_done), 32'd0);
    ret(16'hB000, 1'b0);
    drain_req = 1'b1;
    check("drn_out1",  32'(outstanding), 32'd1);
    check("drn_done2", 32'(drain_done),  32'd0);
    ret(16'hB001, 1'b0);
    drain_req = 1'b1;
    check("drn_out0",  32'(outstanding), 32'd0);
    tick();
    check("drn_done",   32'(drain_done), 32'd1);
    #1 check("drn_d_ready", 32'(req_ready), 32'd0);
    drain_req = 1'b0;
    tick();
    check("drn_exit_done", 32'(drain_done), 32'd0);
    #1 check("drn_exit_ready", 32'(req_ready), 32'd1);
    pop_expect("drn_pop0", 16'hB000);
    pop_expect("drn_pop1", 16'hB001);

    // ---------------- Reset mid-operation ----------------
    issue_read(12'h500);
    check("mid_out", 32'(outstanding), 32'd1);
    do_reset();
    check("mid_rst_out",  32'(outstanding),  32'd0);
    check("mid_rst_mvi",  32'(mem_valid_in), 32'd0);
    check("mid_rst_err",  32'(err),          32'd0);
    ret(16'h9999, 1'b0);
    check("mid_late_err",  32'(err),       32'd1);
    check("mid_late_rspv", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tpm_port_requester.md
TPM_PORT_REQUESTER -- requirements
Module: tpm_port_requester

Interface
REQ-001 Parameter: ADDR_W, 12, memory address width.
REQ-002 Parameter: DATA_W, 16, data width.
REQ-003 Parameter: RSP_DEPTH, 4, response FIFO depth and read-credit limit (power of two, >=2).
REQ-004 Derived: CW = clog2(RSP_DEPTH+1), credit/count width (3 at default).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 req_valid  in  1  client request present.
REQ-008 req_ready  out  1  requester accepts a request this cycle.
REQ-009 req_addr / req_wdata / req_wen  in  ADDR_W / DATA_W / 1  request fields; wen=1 means write.
REQ-010 mem_addr / mem_wdata / mem_wen / mem_valid_in  out  ADDR_W / DATA_W / 1 / 1  registered drive to one memory port.
REQ-011 mem_freeze_inputs  in  1  memory input-hold request.
REQ-012 mem_data_out / mem_valid_out  in  DATA_W / 1  read return from the same port.
REQ-013 rsp_valid / rsp_ready / rsp_data  out / in / out  1 / 1 / DATA_W  client response handshake.
REQ-014 drain_req  in  1  level; stop issuing and wait for in-flight reads.
REQ-015 drain_done  out  1  drain complete.
REQ-016 outstanding  out  CW  reads issued but not yet returned.
REQ-017 err  out  1  sticky protocol error.

Function
REQ-018 Memory accepts the driven request on any rising edge with mem_freeze_inputs=0; only reads produce a mem_valid_out return, one per read, in issue order.
REQ-019 credits = issued reads not yet popped by client (in flight + FIFO entries); credit_ok = credits < RSP_DEPTH.
REQ-020 req_ready = (state==RUN) & ~mem_freeze_inputs & credit_ok, combinational, independent of req_wen and req_valid.
REQ-021 While mem_freeze_inputs=1, all mem_* outputs hold their values exactly.
REQ-022 Each edge with mem_freeze_inputs=0: mem_valid_in <= req_valid & req_ready; on accept, mem_addr/mem_wdata/mem_wen load req fields; else those fields hold last values.
REQ-023 Latency: accepted request appears on mem_* one cycle later; back-to-back throughput one per cycle.
REQ-024 credits +1 on accepted read, -1 on rsp_valid & rsp_ready; both in one cycle gives net 0.
REQ-025 FIFO push on mem_valid_out when outstanding>0 and FIFO not full; data = mem_data_out.
REQ-026 mem_valid_out with outstanding==0 or FIFO full: data dropped, err set, err holds until reset.
REQ-027 rsp_valid = FIFO non-empty; rsp_data = head entry (show-ahead); response visible one cycle after mem_valid_out.
REQ-028 Simultaneous push and pop at full FIFO: pop first, push lands; no error.
REQ-029 outstanding = credits - FIFO count; decrements on push, increments on accepted read.
REQ-030 FIFO pointers wrap modulo RSP_DEPTH.
REQ-031 FSM RUN: drain_req=1 -> DRAINING at next edge.
REQ-032 FSM DRAINING: req_ready=0; -> DRAINED when outstanding==0 and mem_valid_in==0 (or mem_valid_in==1 and captured this edge).
REQ-033 FSM DRAINED: drain_done=1; drain_req=0 -> RUN. FIFO still pops in every state.

Reset
REQ-034 reset_n=0 at an edge: state=RUN, mem_valid_in=0, mem_addr=0, mem_wdata=0, mem_wen=0, FIFO empty, credits=0, outstanding=0, err=0, drain_done=0; rsp_valid=0.
REQ-035 Reset mid-operation discards in-flight reads; a later mem_valid_out sets err per REQ-026.

Verification
REQ-036 Write addr 0x010 data 0xBEEF, freeze=0 -> next cycle mem_valid_in=1, mem_addr=0x010, mem_wdata=0xBEEF, mem_wen=1; outstanding stays 0.
REQ-037 Read 0x123 accepted, freeze=1 for 3 cycles -> mem_* stable, req_ready=0 all 3 cycles; freeze=0 -> captured, mem_valid_in falls if no new request.
REQ-038 Four reads, rsp_ready=0, four returns 0x0001..0x0004 -> req_ready=0 after 4th accept, outstanding 4->0, FIFO full; one pop -> req_ready=1, rsp_data=0x0002.
REQ-039 mem_valid_out=1 with outstanding=0 -> err=1, rsp_valid=0, err held until reset_n=0.
REQ-040 Two reads in flight, drain_req=1 -> DRAINING, req_ready=0; after both returns drain_done=1; drain_req=0 -> RUN, req_ready=1.
REQ-041 FIFO full, push and pop same cycle -> count stays 4, err=0, order preserved across pointer wrap.
